// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: request payload, grant select, counter width.
package dmem_arbiter_pkg;

  localparam int DMEM_XLEN    = 32;
  localparam int DMEM_ADDR_W  = 8;
  localparam int DMEM_BE_W    = DMEM_XLEN / 8;
  localparam int STARVE_CNT_W = 8;

  typedef struct packed {
    logic                   we;
    logic [DMEM_BE_W-1:0]   be;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_XLEN-1:0]   wd;
  } dmem_req_t;

  localparam dmem_req_t DMEM_REQ_IDLE = '0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_AUX  = 2'd2
  } gnt_sel_e;

  function automatic dmem_req_t pack_req(
    input logic                   we,
    input logic [DMEM_BE_W-1:0]   be,
    input logic [DMEM_ADDR_W-1:0] addr,
    input logic [DMEM_XLEN-1:0]   wd
  );
    dmem_req_t r;
    r.we   = we;
    r.be   = be;
    r.addr = addr;
    r.wd   = wd;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating starvation counter: counts denied aux cycles and raises force_gnt at the limit.
module arb_starve_ctr
  import dmem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = STARVE_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic force_gnt
);

  localparam logic [W-1:0] LIMIT_C = W'(LIMIT);

  logic [W-1:0] cnt;

  // Saturation never holds for long: a forced grant is a handshake, which clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_gnt = (cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core has fixed priority, aux gets a forced beat after starvation.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN         = DMEM_XLEN,
  parameter int ADDR_WIDTH   = DMEM_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [XLEN/8-1:0]     core_be,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [XLEN-1:0]       core_wd,
  output logic [XLEN-1:0]       core_rd,
  output logic                  core_stall,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic                  aux_we,
  input  logic [XLEN/8-1:0]     aux_be,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [XLEN-1:0]       aux_wd,
  output logic                  aux_rvalid,
  output logic [XLEN-1:0]       aux_rdata,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wd,
  input  logic [XLEN-1:0]       mem_rd
);

  dmem_req_t core_req_s;
  dmem_req_t aux_req_s;
  dmem_req_t sel_req_s;
  gnt_sel_e  gnt_sel;

  logic force_gnt;
  logic gnt_aux;
  logic gnt_core;
  logic aux_rd_hs;

  logic            vld_p1;
  logic [XLEN-1:0] rdata_p1;

  assign core_req_s = pack_req(core_we, core_be, core_addr, core_wd);
  assign aux_req_s  = pack_req(aux_we, aux_be, aux_addr, aux_wd);

  // Aux only wins against an active core when the starvation limit has been hit.
  assign gnt_aux  = aux_valid & (~core_req | force_gnt);
  assign gnt_core = core_req & ~gnt_aux;

  assign aux_ready  = gnt_aux;
  assign core_stall = core_req & gnt_aux;
  assign aux_rd_hs  = gnt_aux & ~aux_we;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (STARVE_CNT_W)
  ) u_starve_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~aux_valid | gnt_aux),
    .inc       (aux_valid & ~gnt_aux),
    .force_gnt (force_gnt)
  );

  always_comb begin
    gnt_sel = GNT_NONE;
    if (gnt_aux) begin
      gnt_sel = GNT_AUX;
    end else if (gnt_core) begin
      gnt_sel = GNT_CORE;
    end
  end

  // Address/data follow the core payload when idle; only we/be are gated off.
  always_comb begin
    sel_req_s = core_req_s;
    mem_we    = 1'b0;
    mem_be    = '0;
    unique case (gnt_sel)
      GNT_AUX: begin
        sel_req_s = aux_req_s;
        mem_we    = aux_req_s.we;
        mem_be    = aux_req_s.be;
      end
      GNT_CORE: begin
        mem_we = core_req_s.we;
        mem_be = core_req_s.be;
      end
      default: begin
        sel_req_s = core_req_s;
      end
    endcase
  end

  assign mem_addr = sel_req_s.addr;
  assign mem_wd   = sel_req_s.wd;
  assign core_rd  = mem_rd;

  // p0 -> p1: aux read response, one-cycle valid pulse with the captured read word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= aux_rd_hs;
      if (aux_rd_hs) begin
        rdata_p1 <= mem_rd;
      end
    end
  end

  assign aux_rvalid = vld_p1;
  assign aux_rdata  = rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and write/read scoreboards.
module tb_dmem_arbiter;

  localparam int XLEN  = 32;
  localparam int AW    = 8;
  localparam int BEW   = XLEN / 8;
  localparam int LIMIT = 4;

  logic            clk;
  logic            rst_n;
  logic            core_req, core_we;
  logic [BEW-1:0]  core_be;
  logic [AW-1:0]   core_addr;
  logic [XLEN-1:0] core_wd, core_rd;
  logic            core_stall;
  logic            aux_valid, aux_ready, aux_we;
  logic [BEW-1:0]  aux_be;
  logic [AW-1:0]   aux_addr;
  logic [XLEN-1:0] aux_wd;
  logic            aux_rvalid;
  logic [XLEN-1:0] aux_rdata;
  logic            mem_we;
  logic [BEW-1:0]  mem_be;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wd, mem_rd;

  logic [XLEN-1:0]        mem_arr [256];
  logic [AW+XLEN+BEW-1:0] exp_wr [$];
  logic [XLEN-1:0]        exp_rd [$];
  logic [XLEN-1:0]        rd_vals [3];
  int n_checks = 0;
  int n_errors = 0;
  event smp;

  assign mem_rd = mem_arr[mem_addr];

  dmem_arbiter #(
    .XLEN         (XLEN),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wd    (core_wd),
    .core_rd    (core_rd),
    .core_stall (core_stall),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_we     (aux_we),
    .aux_be     (aux_be),
    .aux_addr   (aux_addr),
    .aux_wd     (aux_wd),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Posedge at 5 mod 10, negedge at 0 mod 10, sampling event one unit before each posedge.
  initial begin
    clk = 1'b0;
    forever begin
      #4;
      ->smp;
      #1 clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic core_set(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [XLEN-1:0] wd, input logic [BEW-1:0] be);
    core_req  = req;
    core_we   = we;
    core_addr = addr;
    core_wd   = wd;
    core_be   = be;
  endtask

  task automatic aux_set(input logic vld, input logic we, input logic [AW-1:0] addr,
                         input logic [XLEN-1:0] wd, input logic [BEW-1:0] be);
    aux_valid = vld;
    aux_we    = we;
    aux_addr  = addr;
    aux_wd    = wd;
    aux_be    = be;
  endtask

  // One clock: check/apply the memory write just before the edge, then the read response after it.
  task automatic tick();
    logic [AW+XLEN+BEW-1:0] w;
    logic [XLEN-1:0] r;
    @(smp);
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 64'(mem_we), 64'(0));
      end else begin
        w = exp_wr.pop_front();
        chk("wr_log", 64'({mem_addr, mem_wd, mem_be}), 64'(w));
      end
      for (int b = 0; b < BEW; b++) begin
        if (mem_be[b]) mem_arr[mem_addr][b*8 +: 8] = mem_wd[b*8 +: 8];
      end
    end
    @(negedge clk);
    if (aux_rvalid) begin
      if (exp_rd.size() == 0) begin
        chk("rvalid_unexpected", 64'(aux_rvalid), 64'(0));
      end else begin
        r = exp_rd.pop_front();
        chk("rd_sb", 64'(aux_rdata), 64'(r));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[8'h10] = 32'hDEADBEEF;
    mem_arr[8'h00] = 32'h11111111;
    mem_arr[8'h04] = 32'h22222222;
    mem_arr[8'h08] = 32'h33333333;
    rd_vals[0] = 32'h11111111;
    rd_vals[1] = 32'h22222222;
    rd_vals[2] = 32'h33333333;
    rst_n = 1'b0;
    core_set(1'b0, 1'b0, '0, '0, '0);
    aux_set(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_rvalid", 64'(aux_rvalid), 64'(0));
    chk("rst_rdata", 64'(aux_rdata), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_be", 64'(mem_be), 64'(0));
    aux_set(1'b1, 1'b0, 8'h10, '0, 4'hF);
    #1;
    chk("rst_ready_comb", 64'(aux_ready), 64'(1));
    aux_set(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();
    #2 rst_n = 1'b1;

    // 1: single aux read, core idle
    aux_set(1'b1, 1'b0, 8'h10, '0, 4'hF);
    #1;
    chk("t1_ready", 64'(aux_ready), 64'(1));
    chk("t1_stall", 64'(core_stall), 64'(0));
    chk("t1_addr", 64'(mem_addr), 64'(8'h10));
    chk("t1_we", 64'(mem_we), 64'(0));
    exp_rd.push_back(32'hDEADBEEF);
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t1_rvalid", 64'(aux_rvalid), 64'(1));
    chk("t1_rdata", 64'(aux_rdata), 64'(32'hDEADBEEF));
    chk("t1_stall2", 64'(core_stall), 64'(0));
    chk("idle_be", 64'(mem_be), 64'(0));
    chk("idle_we", 64'(mem_we), 64'(0));
    tick();
    #1;
    chk("t1_rvalid_drop", 64'(aux_rvalid), 64'(0));

    // 2: core stores every cycle, aux read held; forced aux beat in cycle 5
    aux_set(1'b1, 1'b0, 8'h10, '0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      core_set(1'b1, 1'b1, 8'(8'h40 + i), 32'(32'h1000 + i), 4'hF);
      exp_wr.push_back({8'(8'h40 + i), 32'(32'h1000 + i), 4'hF});
      #1;
      chk("t2_ready_low", 64'(aux_ready), 64'(0));
      chk("t2_stall_low", 64'(core_stall), 64'(0));
      chk("t2_core_addr", 64'(mem_addr), 64'(8'h40 + i));
      tick();
    end
    core_set(1'b1, 1'b1, 8'h44, 32'h00001004, 4'hF);
    exp_wr.push_back({8'h44, 32'h00001004, 4'hF});
    #1;
    chk("t2_forced_ready", 64'(aux_ready), 64'(1));
    chk("t2_forced_stall", 64'(core_stall), 64'(1));
    chk("t2_forced_addr", 64'(mem_addr), 64'(8'h10));
    chk("t2_forced_we", 64'(mem_we), 64'(0));
    exp_rd.push_back(32'hDEADBEEF);
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t2_core_back_stall", 64'(core_stall), 64'(0));
    chk("t2_core_back_addr", 64'(mem_addr), 64'(8'h44));
    chk("t2_core_back_we", 64'(mem_we), 64'(1));
    chk("t2_rvalid", 64'(aux_rvalid), 64'(1));
    tick();
    core_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t2_wr_log_empty", 64'(exp_wr.size()), 64'(0));

    // 3: aux partial-byte write, core idle
    aux_set(1'b1, 1'b1, 8'h20, 32'h0000AB00, 4'b0010);
    exp_wr.push_back({8'h20, 32'h0000AB00, 4'b0010});
    #1;
    chk("t3_ready", 64'(aux_ready), 64'(1));
    chk("t3_we", 64'(mem_we), 64'(1));
    chk("t3_be", 64'(mem_be), 64'(4'b0010));
    chk("t3_wd", 64'(mem_wd), 64'(32'h0000AB00));
    chk("t3_addr", 64'(mem_addr), 64'(8'h20));
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t3_no_rvalid", 64'(aux_rvalid), 64'(0));
    chk("t3_mem", 64'(mem_arr[8'h20]), 64'(32'h0000AB00));
    tick();

    // 4: simultaneous stores, core wins, aux lands next
    core_set(1'b1, 1'b1, 8'h30, 32'hC0C0C0C0, 4'hF);
    aux_set(1'b1, 1'b1, 8'h31, 32'hA5A5A5A5, 4'hF);
    exp_wr.push_back({8'h30, 32'hC0C0C0C0, 4'hF});
    exp_wr.push_back({8'h31, 32'hA5A5A5A5, 4'hF});
    #1;
    chk("t4_core_addr", 64'(mem_addr), 64'(8'h30));
    chk("t4_core_wd", 64'(mem_wd), 64'(32'hC0C0C0C0));
    chk("t4_ready_low", 64'(aux_ready), 64'(0));
    tick();
    core_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t4_aux_ready", 64'(aux_ready), 64'(1));
    chk("t4_aux_addr", 64'(mem_addr), 64'(8'h31));
    chk("t4_aux_wd", 64'(mem_wd), 64'(32'hA5A5A5A5));
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t4_no_rvalid", 64'(aux_rvalid), 64'(0));
    chk("t4_wr_log_empty", 64'(exp_wr.size()), 64'(0));
    tick();

    // 5a: reset asserted in the cycle of an aux read handshake kills its response
    aux_set(1'b1, 1'b0, 8'h08, '0, 4'hF);
    #1;
    chk("t5a_ready", 64'(aux_ready), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t5a_ready_in_rst", 64'(aux_ready), 64'(1));
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t5a_rvalid_lost", 64'(aux_rvalid), 64'(0));
    chk("t5a_rdata_clr", 64'(aux_rdata), 64'(0));
    #1 rst_n = 1'b1;

    // 5b: reset mid-starvation (count 3), then 4 more denied cycles before the forced beat
    core_set(1'b1, 1'b0, 8'h00, '0, 4'hF);
    aux_set(1'b1, 1'b0, 8'h10, '0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5b_ready_pre", 64'(aux_ready), 64'(0));
      chk("t5b_core_rd", 64'(core_rd), 64'(32'h11111111));
      tick();
    end
    #1;
    chk("t5b_ready_cnt3", 64'(aux_ready), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("t5b_ready_in_rst", 64'(aux_ready), 64'(0));
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5b_ready_post", 64'(aux_ready), 64'(0));
      chk("t5b_stall_post", 64'(core_stall), 64'(0));
      tick();
    end
    #1;
    chk("t5b_forced_ready", 64'(aux_ready), 64'(1));
    chk("t5b_forced_stall", 64'(core_stall), 64'(1));
    exp_rd.push_back(32'hDEADBEEF);
    tick();
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t5b_core_back", 64'(core_stall), 64'(0));
    chk("t5b_rvalid", 64'(aux_rvalid), 64'(1));
    chk("t5b_rdata", 64'(aux_rdata), 64'(32'hDEADBEEF));
    tick();
    core_set(1'b0, 1'b0, '0, '0, '0);

    // 6: back-to-back aux reads
    for (int i = 0; i < 3; i++) begin
      aux_set(1'b1, 1'b0, 8'(i * 4), '0, 4'hF);
      exp_rd.push_back(rd_vals[i]);
      #1;
      chk("t6_ready", 64'(aux_ready), 64'(1));
      if (i > 0) begin
        chk("t6_rvalid", 64'(aux_rvalid), 64'(1));
        chk("t6_rdata", 64'(aux_rdata), 64'(rd_vals[i-1]));
      end
      tick();
    end
    aux_set(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("t6_rvalid_last", 64'(aux_rvalid), 64'(1));
    chk("t6_rdata_last", 64'(aux_rdata), 64'(rd_vals[2]));
    tick();
    #1;
    chk("t6_rvalid_end", 64'(aux_rvalid), 64'(0));
    tick();

    chk("rd_sb_drained", 64'(exp_rd.size()), 64'(0));
    chk("wr_sb_drained", 64'(exp_wr.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
